// File: rtl/muldiv_pkg.sv
// Shared encodings, state type and helpers for the iterative
// multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_seq_core.sv
// Shared shift-add / restoring-divide datapath.
// The accumulator's top half holds the remainder and its bottom half holds the quotient.
module muldiv_seq_core #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              word,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc,
    output logic              last
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0]   a_r;
    logic [XLEN-1:0]   b_r;
    logic              div_r;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] mul_nxt;
    logic [XLEN:0]     shifted;
    logic [XLEN+1:0]   diff;
    logic              abit;
    logic              ge;

    assign last = (cnt == '0);

    always_comb begin
        abit    = a_r[cnt];
        mul_nxt = {acc[2*XLEN-2:0], 1'b0}
                + (abit ? {{XLEN{1'b0}}, b_r} : '0);
        shifted = {acc[2*XLEN-1:XLEN], abit};
        diff    = {1'b0, shifted} - {2'b00, b_r};
        ge      = !diff[XLEN+1];
        acc_nxt = mul_nxt;
        if (div_r) begin
            acc_nxt[2*XLEN-1:XLEN] = ge ? diff[XLEN-1:0]
                                        : shifted[XLEN-1:0];
            acc_nxt[XLEN-1:0]      = {acc[XLEN-2:0], ge};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r   <= '0;
            b_r   <= '0;
            div_r <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
        end else if (load) begin
            a_r   <= a;
            b_r   <= b;
            div_r <= is_div;
            cnt   <= word ? CW'(31) : CW'(XLEN - 1);
            acc   <= '0;
        end else if (step) begin
            acc <= acc_nxt;
            if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV M-extension unit: handshake FSM, operand prep,
// special-case detection and sign fix-up around the shared core.
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5,
    parameter int W_OPS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam bit WEN = (W_OPS != 0) && (XLEN == 64);

    state_t            state_q, state_d;
    logic              accept, wd, a_sgn, b_sgn, is_div, is_rem;
    logic              na, nb, dz, ovf, special, neg;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_v, spec_v;
    logic [2:0]        f3_r;
    logic              word_r, neg_r, spec_r;
    logic [XLEN-1:0]   spec_val_r;
    logic [TAG_W-1:0]  tag_r;
    logic [2*XLEN-1:0] acc, src2x, fix;
    logic [XLEN-1:0]   pick, val;
    logic              last, hi_sel;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_tag   = tag_r;
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        wd     = WEN && in_word;
        is_div = in_funct3[2];
        is_rem = is_div && in_funct3[1];
        a_sgn  = 1'b0;
        b_sgn  = 1'b0;
        unique case (in_funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            F3_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
        a_ext = in_a;
        b_ext = in_b;
        min_v = {1'b1, {(XLEN-1){1'b0}}};
        if (wd) begin
            a_ext = a_sgn ? XLEN'(sext32(in_a[31:0])) : XLEN'(in_a[31:0]);
            b_ext = b_sgn ? XLEN'(sext32(in_b[31:0])) : XLEN'(in_b[31:0]);
            min_v = XLEN'(sext32(32'h8000_0000));
        end
        na    = a_sgn && a_ext[XLEN-1];
        nb    = b_sgn && b_ext[XLEN-1];
        a_mag = na ? -a_ext : a_ext;
        b_mag = nb ? -b_ext : b_ext;
        neg   = is_rem ? na : (na ^ nb);
        dz    = is_div && (b_ext == '0);
        ovf   = is_div && b_sgn && (a_ext == min_v) && (&b_ext);
        special = dz || ovf;
        // The overflow quotient equals the (extended) dividend MIN itself.
        if (dz)
            spec_v = is_rem ? (wd ? XLEN'(sext32(in_a[31:0])) : in_a) : '1;
        else
            spec_v = is_rem ? '0 : a_ext;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = special ? DONE : BUSY;
            BUSY: if (last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            f3_r       <= '0;
            word_r     <= 1'b0;
            neg_r      <= 1'b0;
            spec_r     <= 1'b0;
            spec_val_r <= '0;
            tag_r      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f3_r       <= in_funct3;
                word_r     <= wd;
                neg_r      <= neg;
                spec_r     <= special;
                spec_val_r <= spec_v;
                tag_r      <= in_tag;
            end
        end
    end

    muldiv_seq_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   ((state_q == BUSY) && !flush),
        .word   (wd),
        .is_div (is_div),
        .a      (a_mag),
        .b      (b_mag),
        .acc    (acc),
        .last   (last)
    );

    // Negate over the full 2N width so high-half multiplies carry correctly.
    always_comb begin
        if (f3_r[2])
            src2x = {{XLEN{1'b0}},
                     f3_r[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0]};
        else
            src2x = acc;
        fix    = neg_r ? -src2x : src2x;
        hi_sel = !f3_r[2] && (f3_r[1:0] != 2'b00);
        pick   = hi_sel ? fix[2*XLEN-1:XLEN] : fix[XLEN-1:0];
        val    = word_r ? XLEN'(sext32(pick[31:0])) : pick;
        out_result = '0;
        if (out_valid)
            out_result = spec_r ? spec_val_r : val;
    end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed-vector bench for muldiv_iter_unit (XLEN=64, W ops on).
module tb_muldiv_iter_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_word;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;

    int errors = 0;
    int checks = 0;

    muldiv_iter_unit #(
        .XLEN  (64),
        .TAG_W (5),
        .W_OPS (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_word    (in_word),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    // Issues one op; lat counts rising edges from the accept edge (=1)
    // until out_valid is seen. Capped at 200.
    task automatic issue(input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] t, input bit consume,
                         output logic [63:0] res, output logic [4:0] tg,
                         output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_funct3 = f3;
        in_word   = w;
        in_a      = a;
        in_b      = b;
        in_tag    = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_result;
        tg  = out_tag;
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0",
                     in_ready, out_valid);
        end
        checks++;
        if (out_result !== 64'd0 || out_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: result=%h tag=%h want 0 0",
                     out_result, out_tag);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_mul();
        logic [63:0] r;
        logic [4:0]  t;
        int          l;
        issue(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 1'b1, r, t, l);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL mul_res: got %h want ffffffffffffffeb", r);
        end
        checks++;
        if (t !== 5'd5) begin
            errors++;
            $display("FAIL mul_tag: got %0d want 5", t);
        end
        checks++;
        if (l != 65) begin
            errors++;
            $display("FAIL mul_lat: got %0d want 65", l);
        end
    endtask

    task automatic test_mulh();
        logic [63:0] r;
        logic [4:0]  t;
        int          l;
        issue(3'd3, 1'b0, '1, '1, 5'd1, 1'b1, r, t, l);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++;
            $display("FAIL mulhu_res: got %h want fffffffffffffffe", r);
        end
        issue(3'd1, 1'b0, '1, '1, 5'd2, 1'b1, r, t, l);
        checks++;
        if (r !== 64'd0) begin
            errors++;
            $display("FAIL mulh_res: got %h want 0", r);
        end
        issue(3'd2, 1'b0, '1, 64'd2, 5'd3, 1'b1, r, t, l);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL mulhsu_res: got %h want ffffffffffffffff", r);
        end
    endtask

    task automatic test_div_special();
        logic [63:0] r;
        logic [4:0]  t;
        int          l;
        issue(3'd5, 1'b0, 64'd100, 64'd0, 5'd6, 1'b1, r, t, l);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || l != 1) begin
            errors++;
            $display("FAIL divu_zero: got %h lat %0d want all-ones lat 1", r, l);
        end
        issue(3'd7, 1'b0, 64'd100, 64'd0, 5'd7, 1'b1, r, t, l);
        checks++;
        if (r !== 64'd100 || l != 1) begin
            errors++;
            $display("FAIL remu_zero: got %h lat %0d want 64 lat 1", r, l);
        end
        issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd8, 1'b1, r, t, l);
        checks++;
        if (r !== 64'h8000_0000_0000_0000 || l != 1) begin
            errors++;
            $display("FAIL div_ovf: got %h lat %0d want 8000000000000000 lat 1",
                     r, l);
        end
        issue(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd9, 1'b1, r, t, l);
        checks++;
        if (r !== 64'd0 || l != 1) begin
            errors++;
            $display("FAIL rem_ovf: got %h lat %0d want 0 lat 1", r, l);
        end
    endtask

    task automatic test_divw();
        logic [63:0] r;
        logic [4:0]  t;
        int          l;
        issue(3'd4, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 5'd10, 1'b1, r, t, l);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("FAIL divw_res: got %h want fffffffffffffffd", r);
        end
        checks++;
        if (l != 33) begin
            errors++;
            $display("FAIL divw_lat: got %0d want 33", l);
        end
        issue(3'd6, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 5'd11, 1'b1, r, t, l);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL remw_res: got %h want ffffffffffffffff", r);
        end
    endtask

    task automatic test_hold();
        logic [63:0] r;
        logic [4:0]  t;
        int          l;
        issue(3'd0, 1'b0, 64'd6, 64'd7, 5'd12, 1'b0, r, t, l);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_result !== 64'd42
                || out_tag !== 5'd12 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: v=%b res=%h tag=%0d rdy=%b want 1 2a 12 0",
                         i, out_valid, out_result, out_tag, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: v=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        bit seen;
        @(negedge clk);
        in_valid  = 1'b1;
        in_funct3 = 3'd5;
        in_word   = 1'b0;
        in_a      = 64'd1000;
        in_b      = 64'd7;
        in_tag    = 5'd13;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_novalid: out_valid rose got 1 want 0");
        end
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_block: rdy=%b want 1", in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        in_valid  = 1'b1;
        in_funct3 = 3'd0;
        in_word   = 1'b0;
        in_a      = 64'd3;
        in_b      = 64'd5;
        in_tag    = 5'd14;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1
            || out_result !== 64'd0 || out_tag !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid: v=%b rdy=%b res=%h tag=%0d want 0 1 0 0",
                     out_valid, in_ready, out_result, out_tag);
        end
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_novalid: out_valid rose got 1 want 0");
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        logic [4:0]  t;
        int          l;
        issue(3'd7, 1'b0, 64'd100, 64'd7, 5'd15, 1'b1, r, t, l);
        checks++;
        if (r !== 64'd2 || l != 65) begin
            errors++;
            $display("FAIL b2b_remu: got %h lat %0d want 2 lat 65", r, l);
        end
        issue(3'd0, 1'b1, 64'h0000_0000_4000_0000, 64'd3, 5'd16, 1'b1, r, t, l);
        checks++;
        if (r !== 64'hFFFF_FFFF_C000_0000 || l != 33 || t !== 5'd16) begin
            errors++;
            $display("FAIL b2b_mulw: got %h lat %0d tag %0d want ffffffffc0000000 33 16",
                     r, l, t);
        end
    endtask

    initial begin
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_funct3 = 3'd0;
        in_word   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        test_reset();
        test_mul();
        test_mulh();
        test_div_special();
        test_divw();
        test_hold();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
